// File: rtl/arm_pkg.sv
// Shared widths, ALU command encodings and the ID/EX control bundle
// for the 5-stage ARM core pipeline.
package arm_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int CMD_W  = 4;

  localparam logic [CMD_W-1:0] EXE_CMD_NOP = 4'b0000;
  localparam logic [CMD_W-1:0] EXE_CMD_MOV = 4'b0001;
  localparam logic [CMD_W-1:0] EXE_CMD_ADD = 4'b0010;
  localparam logic [CMD_W-1:0] EXE_CMD_ADC = 4'b0011;
  localparam logic [CMD_W-1:0] EXE_CMD_SUB = 4'b0100;
  localparam logic [CMD_W-1:0] EXE_CMD_SBC = 4'b0101;
  localparam logic [CMD_W-1:0] EXE_CMD_AND = 4'b0110;
  localparam logic [CMD_W-1:0] EXE_CMD_ORR = 4'b0111;
  localparam logic [CMD_W-1:0] EXE_CMD_EOR = 4'b1000;
  localparam logic [CMD_W-1:0] EXE_CMD_MVN = 4'b1001;

  typedef struct packed {
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             b;
    logic             s;
    logic [CMD_W-1:0] exe_cmd;
  } id_ex_ctrl_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset, clear beats enable.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q_reg <= '0;
    else if (clr) q_reg <= '0;
    else if (en)  q_reg <= d;
  end

  assign q = q_reg;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded control and operands, with
// freeze (hold) for hazards and bubble insertion for flushes / invalid slots.
module id_ex_stage_reg #(
  parameter int DATA_W = arm_pkg::DATA_W,
  parameter int REG_AW = arm_pkg::REG_AW,
  parameter int CMD_W  = arm_pkg::CMD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              WB_EN_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic              B_in,
  input  logic              S_in,
  input  logic [CMD_W-1:0]  EXE_CMD_in,
  input  logic              imm_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [DATA_W-1:0] Val_Rn_in,
  input  logic [DATA_W-1:0] Val_Rm_in,
  input  logic [11:0]       Shift_operand_in,
  input  logic [23:0]       Signed_imm_24_in,
  input  logic [REG_AW-1:0] Dest_in,
  input  logic [REG_AW-1:0] src1_in,
  input  logic [REG_AW-1:0] src2_in,
  input  logic [3:0]        SR_in,
  input  logic              fwd_en_in,
  output logic              WB_EN_out,
  output logic              MEM_R_EN_out,
  output logic              MEM_W_EN_out,
  output logic              B_out,
  output logic              S_out,
  output logic [CMD_W-1:0]  EXE_CMD_out,
  output logic              imm_out,
  output logic [DATA_W-1:0] PC_out,
  output logic [DATA_W-1:0] Val_Rn_out,
  output logic [DATA_W-1:0] Val_Rm_out,
  output logic [11:0]       Shift_operand_out,
  output logic [23:0]       Signed_imm_24_out,
  output logic [REG_AW-1:0] Dest_out,
  output logic [REG_AW-1:0] src1_out,
  output logic [REG_AW-1:0] src2_out,
  output logic [3:0]        SR_out,
  output logic              fwd_en_out,
  output logic              ex_valid
);

  import arm_pkg::*;

  localparam int CTRL_BITS = $bits(id_ex_ctrl_t) + 1;
  localparam int DATA_BITS = 1 + 3*DATA_W + 12 + 24 + 3*REG_AW + 4;

  logic                 load_en;
  logic                 load_clr;
  id_ex_ctrl_t          ctrl_in;
  id_ex_ctrl_t          ctrl_out;
  logic [CTRL_BITS-1:0] ctrl_d;
  logic [CTRL_BITS-1:0] ctrl_q;
  logic [DATA_BITS-1:0] data_d;
  logic [DATA_BITS-1:0] data_q;

  // A stalled invalid slot is held like any other; only a flush or an
  // advancing invalid slot turns the register into a bubble.
  assign load_en  = ~freeze | flush;
  assign load_clr = flush | (~freeze & ~id_valid);

  assign ctrl_in.wb_en    = WB_EN_in;
  assign ctrl_in.mem_r_en = MEM_R_EN_in;
  assign ctrl_in.mem_w_en = MEM_W_EN_in;
  assign ctrl_in.b        = B_in;
  assign ctrl_in.s        = S_in;
  assign ctrl_in.exe_cmd  = EXE_CMD_in;

  assign ctrl_d = {id_valid, ctrl_in};
  assign data_d = {imm_in, PC_in, Val_Rn_in, Val_Rm_in, Shift_operand_in,
                   Signed_imm_24_in, Dest_in, src1_in, src2_in, SR_in};

  pipe_reg #(.W(CTRL_BITS)) u_ctrl_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .clr   (load_clr),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  pipe_reg #(.W(DATA_BITS)) u_data_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .clr   (load_clr),
    .d     (data_d),
    .q     (data_q)
  );

  // The forwarding mode bit survives bubbles: it never sees the clear.
  pipe_reg #(.W(1)) u_fwd_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .clr   (1'b0),
    .d     (fwd_en_in),
    .q     (fwd_en_out)
  );

  assign {ex_valid, ctrl_out} = ctrl_q;
  assign WB_EN_out    = ctrl_out.wb_en;
  assign MEM_R_EN_out = ctrl_out.mem_r_en;
  assign MEM_W_EN_out = ctrl_out.mem_w_en;
  assign B_out        = ctrl_out.b;
  assign S_out        = ctrl_out.s;
  assign EXE_CMD_out  = ctrl_out.exe_cmd;

  assign {imm_out, PC_out, Val_Rn_out, Val_Rm_out, Shift_operand_out,
          Signed_imm_24_out, Dest_out, src1_out, src2_out, SR_out} = data_q;

endmodule
